// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and default parameter values for the PLL reset/lock supervisor.
package pll_rst_ctrl_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_STABLE  = 2'd1,
        S_RUN     = 2'd2,
        S_PLL_RST = 2'd3
    } state_t;

    localparam int unsigned DEF_STABLE_CYCLES  = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEF_PLL_RST_CYCLES = 4;
    localparam int unsigned DEF_CNT_W          = 8;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_rst_ctrl_if.sv
// Lock flag in, PLL reset / system reset / status out, between supervisor and system.
interface pll_rst_ctrl_if
    import pll_rst_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             locked;
    logic             pll_rst;
    logic             rst_out;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;

    modport master (input locked, output pll_rst, output rst_out, output ready, output lock_loss_cnt);
    modport slave  (output locked, input pll_rst, input rst_out, input ready, input lock_loss_cnt);
endinterface

// File: rtl/pll_rst_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer, asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/pll_rst_ctrl.sv
// Lock qualifier / PLL re-reset supervisor on refclk.
// PLL_RST_CTRL_LOCK_LOSS_CNT_EN builds the saturating lock-loss counter; otherwise it reads 0.
module pll_rst_ctrl
    import pll_rst_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic           refclk,
    input  logic           rst,
    pll_rst_ctrl_if.master bus
);
    localparam int unsigned TMR_MAX = max3(TIMEOUT_CYCLES, STABLE_CYCLES, PLL_RST_CYCLES);
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] C_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_STABLE  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_PLL_RST = TMR_W'(PLL_RST_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             r_rst_out;
    logic             r_pll_rst;
    logic             w_locked_s;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (bus.locked),
        .o_q (w_locked_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT: begin
                if (w_locked_s)
                    w_state_nxt = S_STABLE;
                else if (r_timer == C_TIMEOUT)
                    w_state_nxt = S_PLL_RST;
            end
            S_STABLE: begin
                if (!w_locked_s)
                    w_state_nxt = S_WAIT;
                else if (r_timer == C_STABLE)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!w_locked_s)
                    w_state_nxt = S_WAIT;
            end
            S_PLL_RST: begin
                if (r_timer == C_PLL_RST)
                    w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Outputs registered from next state: same timing as decoding r_state, but glitch-free.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= S_WAIT;
            r_timer   <= '0;
            r_rst_out <= 1'b1;
            r_pll_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
            r_rst_out <= (w_state_nxt != S_RUN);
            r_pll_rst <= (w_state_nxt == S_PLL_RST);
        end
    end

`ifdef PLL_RST_CTRL_LOCK_LOSS_CNT_EN
    logic             w_loss;
    logic [CNT_W-1:0] r_lock_loss_cnt;

    assign w_loss = (r_state == S_RUN) && !w_locked_s;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst)
            r_lock_loss_cnt <= '0;
        else if (w_loss && (r_lock_loss_cnt != '1))
            r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
    end

    assign bus.lock_loss_cnt = r_lock_loss_cnt;
`else
    assign bus.lock_loss_cnt = {CNT_W{1'b0}};
`endif

    assign bus.rst_out = r_rst_out;
    assign bus.ready   = !r_rst_out;
    assign bus.pll_rst = r_pll_rst;
endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: run-length reference model checked every cycle, plus directed literal checks.
module tb_pll_rst_ctrl;
    localparam int unsigned S_CYC = 16;
    localparam int unsigned T_CYC = 20;
    localparam int unsigned P_CYC = 4;
    localparam int unsigned CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pll_rst_ctrl_if #(.CNT_W(CW)) bus ();

    pll_rst_ctrl #(
        .STABLE_CYCLES  (S_CYC),
        .TIMEOUT_CYCLES (T_CYC),
        .PLL_RST_CYCLES (P_CYC),
        .CNT_W          (CW)
    ) dut (
        .refclk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in run-length terms: consecutive qualified-high samples,
    // cycles spent waiting without lock, and remaining PLL reset pulse length.
    logic m_d1, m_d2, m_ls;
    int   m_hi_run, m_wait_age, m_pulse_left, m_losses;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 = 1'b0; m_d2 = 1'b0;
            m_hi_run = 0; m_wait_age = 0; m_pulse_left = 0; m_losses = 0;
        end else begin
            m_ls = m_d2;
            m_d2 = m_d1;
            m_d1 = bus.locked;
            if (m_pulse_left > 0) begin
                m_pulse_left--;
                if (m_pulse_left == 0) begin
                    m_wait_age = 0;
                    m_hi_run   = 0;
                end
            end else if (m_ls) begin
                m_hi_run++;
            end else if (m_hi_run > 0) begin
                if (m_hi_run > S_CYC) m_losses++;
                m_hi_run   = 0;
                m_wait_age = 0;
            end else if (m_wait_age == T_CYC - 1) begin
                m_pulse_left = P_CYC;
            end else begin
                m_wait_age++;
            end
        end
    end

    function automatic logic [31:0] exp_cnt();
`ifdef PLL_RST_CTRL_LOCK_LOSS_CNT_EN
        return (m_losses > 255) ? 32'd255 : 32'(m_losses);
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("model_pll_rst", 32'(bus.pll_rst), 32'(m_pulse_left > 0));
            check("model_rst_out", 32'(bus.rst_out), 32'(!(m_hi_run > S_CYC)));
            check("model_ready",   32'(bus.ready),   32'(m_hi_run > S_CYC));
            check("model_cnt",     32'(bus.lock_loss_cnt), exp_cnt());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] sat_exp;
    int n;

    initial begin
`ifdef PLL_RST_CTRL_LOCK_LOSS_CNT_EN
        sat_exp = 32'd255;
`else
        sat_exp = 32'd0;
`endif
        bus.locked = 1'b0;
        repeat (3) tick();
        check("reset_rst_out", 32'(bus.rst_out), 32'd1);
        check("reset_ready",   32'(bus.ready),   32'd0);
        check("reset_pll_rst", 32'(bus.pll_rst), 32'd0);
        check("reset_cnt",     32'(bus.lock_loss_cnt), 32'd0);
        rst = 1'b0;

        // idle without lock, well short of the timeout
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_pll_rst", 32'(bus.pll_rst), 32'd0);
            check("idle_rst_out", 32'(bus.rst_out), 32'd1);
        end

        // lock acquisition: release after edge 19
        bus.locked = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            check("lock_release", 32'(bus.rst_out), (e < 19) ? 32'd1 : 32'd0);
        end
        check("lock_ready", 32'(bus.ready), 32'd1);

        // lock loss in RUN: reset after 3 edges, counter 0 -> 1
        bus.locked = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("loss_rst_out", 32'(bus.rst_out), (e == 3) ? 32'd1 : 32'd0);
        end
`ifdef PLL_RST_CTRL_LOCK_LOSS_CNT_EN
        check("loss_cnt", 32'(bus.lock_loss_cnt), 32'd1);
`else
        check("loss_cnt", 32'(bus.lock_loss_cnt), 32'd0);
`endif

        // glitch during qualification restarts it
        bus.locked = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("qual_hold", 32'(bus.rst_out), 32'd1);
        end
        bus.locked = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("glitch_hold", 32'(bus.rst_out), 32'd1);
        end
        bus.locked = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            check("requal_release", 32'(bus.rst_out), (e < 19) ? 32'd1 : 32'd0);
        end

        // repeated lock losses saturate the counter
        for (int k = 0; k < 300; k++) begin
            bus.locked = 1'b0;
            repeat (4) tick();
            bus.locked = 1'b1;
            repeat (22) tick();
        end
        check("sat_cnt", 32'(bus.lock_loss_cnt), sat_exp);
        check("sat_running", 32'(bus.rst_out), 32'd0);

        // timeout: pulse 20 cycles after WAIT entry, 4 wide, period 24
        bus.locked = 1'b0;
        repeat (3) tick();
        check("to_entry_rst_out", 32'(bus.rst_out), 32'd1);
        n = 0;
        do begin tick(); n++; end while (!bus.pll_rst && n < 100);
        check("to_delay", 32'(n), 32'd20);
        n = 0;
        while (bus.pll_rst && n < 100) begin tick(); n++; end
        check("to_width", 32'(n), 32'd4);
        n = 0;
        while (!bus.pll_rst && n < 100) begin tick(); n++; end
        check("to_repeat", 32'(n), 32'd20);

        // reset in the 2nd cycle of the pulse truncates it
        tick();
        check("pulse_cycle2", 32'(bus.pll_rst), 32'd1);
        #5 rst = 1'b1;
        #1;
        check("rst_trunc_pll_rst", 32'(bus.pll_rst), 32'd0);
        check("rst_trunc_rst_out", 32'(bus.rst_out), 32'd1);
        check("rst_trunc_ready",   32'(bus.ready),   32'd0);
        check("rst_trunc_cnt",     32'(bus.lock_loss_cnt), 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
